// File: rtl/usb_rx_pkt_ctrl_if.sv
// -----------------------------------------------------------------------------
// usb_rx_pkt_ctrl_if
// Groups every non-clock, non-reset signal of usb_rx_pkt_ctrl into one bundle.
//
// Modports:
//   master : the surroundings. It drives the RX decoder outputs, buffer status,
//            toggle clear and tx_ack, and observes everything the controller
//            produces.
//   slave  : the packet controller itself.
//
// Signals:
//   rx_packet[2:0]       packet kind from RX decoder (0 none, 1 OUT, 2 IN,
//                        3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 BAD)
//   rx_packet_data[7:0]  payload byte, valid with store_rx_packet_data
//   store_rx_packet_data 1-cycle byte strobe
//   buf_full             RX buffer cannot take a byte this cycle
//   toggle_clear         force the expected toggle back to DATA0
//   tx_ack               TX side accepted the handshake request
//   buf_wr_en/buf_wr_data     byte write into the RX buffer
//   buf_commit/buf_rollback   keep or discard bytes written since last decision
//   tx_req/tx_pid        handshake request (01 ACK, 10 NAK)
//   rx_data_ready        good packet committed
//   rx_byte_count        payload length of the last committed packet
//   rx_busy              controller not idle
//   expected_toggle      0 = expect DATA0, 1 = expect DATA1
//   err_count[7:0]       only with USB_RX_PKT_CTRL_STATS_EN defined
// -----------------------------------------------------------------------------
interface usb_rx_pkt_ctrl_if #(
    parameter int MAX_PKT = 64
);
    localparam int CNT_W = $clog2(MAX_PKT + 1);

    logic [2:0]       rx_packet;
    logic [7:0]       rx_packet_data;
    logic             store_rx_packet_data;
    logic             buf_full;
    logic             toggle_clear;
    logic             tx_ack;

    logic             buf_wr_en;
    logic [7:0]       buf_wr_data;
    logic             buf_commit;
    logic             buf_rollback;
    logic             tx_req;
    logic [1:0]       tx_pid;
    logic             rx_data_ready;
    logic [CNT_W-1:0] rx_byte_count;
    logic             rx_busy;
    logic             expected_toggle;
`ifdef USB_RX_PKT_CTRL_STATS_EN
    logic [7:0]       err_count;
`endif

    modport master (
        output rx_packet, rx_packet_data, store_rx_packet_data,
               buf_full, toggle_clear, tx_ack,
`ifdef USB_RX_PKT_CTRL_STATS_EN
        input  err_count,
`endif
        input  buf_wr_en, buf_wr_data, buf_commit, buf_rollback, tx_req,
               tx_pid, rx_data_ready, rx_byte_count, rx_busy, expected_toggle
    );

    modport slave (
        input  rx_packet, rx_packet_data, store_rx_packet_data,
               buf_full, toggle_clear, tx_ack,
`ifdef USB_RX_PKT_CTRL_STATS_EN
        output err_count,
`endif
        output buf_wr_en, buf_wr_data, buf_commit, buf_rollback, tx_req,
               tx_pid, rx_data_ready, rx_byte_count, rx_busy, expected_toggle
    );
endinterface

// File: rtl/usb_rx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// usb_rx_pkt_ctrl
// Packet-level sequencer behind the USB RX datapath. After an OUT token it
// streams payload bytes into the endpoint RX buffer. When the DATA packet ends
// it either commits or rolls back those bytes, tracks the DATA0/DATA1 toggle
// and requests an ACK or NAK handshake from the TX side.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (the RX buffer shares it)
//   bus   usb_rx_pkt_ctrl_if.slave, carrying all data/handshake/status signals
//
// Parameters:
//   MAX_PKT         max payload bytes per DATA packet
//   TIMEOUT_CYCLES  allowed silence after OUT or between bytes
//
// Optional feature: define USB_RX_PKT_CTRL_STATS_EN to get err_count, a
// saturating count of timeouts, BAD packets mid-transaction and overflow NAKs.
// -----------------------------------------------------------------------------
module usb_rx_pkt_ctrl #(
    parameter int MAX_PKT        = 64,
    parameter int TIMEOUT_CYCLES = 144
) (
    input  logic               clk,
    input  logic               rst,
    usb_rx_pkt_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_PKT + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PKT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] PID_OUT   = 3'd1;
    localparam logic [2:0] PID_DATA0 = 3'd3;
    localparam logic [2:0] PID_DATA1 = 3'd4;
    localparam logic [2:0] PID_BAD   = 3'd7;

    localparam logic [1:0] HS_ACK = 2'b01;
    localparam logic [1:0] HS_NAK = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_RECV_DATA,
        S_DECIDE,
        S_SEND_HS
    } state_t;

    state_t           state_q;
    logic [2:0]       prev_pkt_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic [TMR_W-1:0] timer_q;
    logic             toggle_q;
    logic             pid_tog_q;
    logic             wr_en_q;
    logic [7:0]       wr_data_q;
    logic             commit_q;
    logic             rollback_q;
    logic             tx_req_q;
    logic [1:0]       tx_pid_q;
    logic             ready_q;
    logic [CNT_W-1:0] byte_count_q;

    logic pkt_event;
    logic in_rx;
    logic store;
    logic can_write;
    logic is_data;
    logic timeout;

    // A packet is seen once, on the first cycle its kind becomes non-zero.
    assign pkt_event = (bus.rx_packet != 3'd0) && (prev_pkt_q == 3'd0);
    assign in_rx     = (state_q == S_WAIT_DATA) || (state_q == S_RECV_DATA);
    assign store     = bus.store_rx_packet_data;
    assign can_write = in_rx && store && !bus.buf_full && (count_q < MAX_CNT);
    assign is_data   = (bus.rx_packet == PID_DATA0) || (bus.rx_packet == PID_DATA1);
    assign timeout   = (timer_q == TMR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prev_pkt_q   <= 3'd0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            timer_q      <= '0;
            toggle_q     <= 1'b0;
            pid_tog_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 8'd0;
            commit_q     <= 1'b0;
            rollback_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            tx_pid_q     <= 2'b00;
            ready_q      <= 1'b0;
            byte_count_q <= '0;
        end else begin
            prev_pkt_q <= bus.rx_packet;
            wr_en_q    <= 1'b0;
            commit_q   <= 1'b0;
            rollback_q <= 1'b0;
            ready_q    <= 1'b0;

            // The byte path runs ahead of the state logic so a strobe arriving
            // together with the DATA event is already counted at decide time.
            if (can_write) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= bus.rx_packet_data;
                count_q   <= count_q + 1'b1;
            end else if (in_rx && store) begin
                ovf_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (pkt_event && bus.rx_packet == PID_OUT) begin
                        state_q <= S_WAIT_DATA;
                        timer_q <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                S_WAIT_DATA, S_RECV_DATA: begin
                    if (pkt_event) begin
                        if (is_data) begin
                            state_q   <= S_DECIDE;
                            pid_tog_q <= (bus.rx_packet == PID_DATA1);
                        end else begin
                            state_q <= S_IDLE;
                            // Only discard when bytes may actually be sitting
                            // uncommitted in the buffer.
                            if (state_q == S_RECV_DATA || can_write)
                                rollback_q <= 1'b1;
                        end
                    end else if (store) begin
                        state_q <= S_RECV_DATA;
                        timer_q <= '0;
                    end else if (timeout) begin
                        state_q <= S_IDLE;
                        if (state_q == S_RECV_DATA)
                            rollback_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DECIDE: begin
                    state_q  <= S_SEND_HS;
                    tx_req_q <= 1'b1;
                    if (ovf_q) begin
                        rollback_q <= 1'b1;
                        tx_pid_q   <= HS_NAK;
                    end else if (pid_tog_q != toggle_q) begin
                        // Retransmission of a packet already accepted: ACK it
                        // again so the host moves on, but keep no data.
                        rollback_q <= 1'b1;
                        tx_pid_q   <= HS_ACK;
                    end else begin
                        commit_q     <= 1'b1;
                        ready_q      <= 1'b1;
                        byte_count_q <= count_q;
                        tx_pid_q     <= HS_ACK;
                        toggle_q     <= ~toggle_q;
                    end
                end
                S_SEND_HS: begin
                    if (bus.tx_ack) begin
                        tx_req_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Placed last so an endpoint reconfiguration beats a flip.
            if (bus.toggle_clear)
                toggle_q <= 1'b0;
        end
    end

    assign bus.buf_wr_en       = wr_en_q;
    assign bus.buf_wr_data     = wr_data_q;
    assign bus.buf_commit      = commit_q;
    assign bus.buf_rollback    = rollback_q;
    assign bus.tx_req          = tx_req_q;
    assign bus.tx_pid          = tx_pid_q;
    assign bus.rx_data_ready   = ready_q;
    assign bus.rx_byte_count   = byte_count_q;
    assign bus.rx_busy         = (state_q != S_IDLE);
    assign bus.expected_toggle = toggle_q;

`ifdef USB_RX_PKT_CTRL_STATS_EN
    logic [7:0] err_q;
    logic       err_inc;

    always_comb begin
        err_inc = 1'b0;
        if (in_rx) begin
            if (pkt_event)
                err_inc = (bus.rx_packet == PID_BAD);
            else if (!store && timeout)
                err_inc = 1'b1;
        end else if (state_q == S_DECIDE) begin
            err_inc = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 8'd0;
        else if (err_inc && err_q != 8'hFF)
            err_q <= err_q + 8'd1;
    end

    assign bus.err_count = err_q;
`endif

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
module tb_usb_rx_pkt_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    usb_rx_pkt_ctrl_if bus_if ();

    usb_rx_pkt_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    typedef struct {
        logic       commit;
        logic [6:0] count;
        logic [1:0] hs;     // 0 none, 1 ACK, 2 NAK
    } out_t;

    logic [7:0] exp_wr_q[$];
    out_t       exp_out_q[$];
    logic [1:0] exp_hs_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_req = 1'b0;
    logic auto_ack = 1'b1;

    // model state
    logic       m_toggle = 1'b0;
    int         m_count  = 0;
    logic       m_ovf    = 1'b0;

    // One clock; sample outputs 1 time unit after the edge and score them.
    task automatic tick();
        logic [7:0] w;
        out_t       o;
        logic [1:0] h;
        @(posedge clk);
        #1;
        if (bus_if.buf_wr_en) begin
            n_cmp++;
            if (exp_wr_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got data %02h, required no write", bus_if.buf_wr_data);
            end else begin
                w = exp_wr_q.pop_front();
                if (bus_if.buf_wr_data !== w) begin
                    n_err++;
                    $display("FAIL wr_data: got %02h, required %02h", bus_if.buf_wr_data, w);
                end
            end
        end
        if (bus_if.buf_commit || bus_if.buf_rollback) begin
            n_cmp++;
            if (bus_if.buf_commit && bus_if.buf_rollback) begin
                n_err++;
                $display("FAIL commit_and_rollback: got both, required one");
            end else if (exp_out_q.size() == 0) begin
                n_err++;
                $display("FAIL pulse_unexpected: got commit=%0b rollback=%0b, required none",
                         bus_if.buf_commit, bus_if.buf_rollback);
            end else begin
                o = exp_out_q.pop_front();
                if (bus_if.buf_commit !== o.commit || bus_if.rx_data_ready !== o.commit) begin
                    n_err++;
                    $display("FAIL outcome: got commit=%0b ready=%0b, required commit=%0b ready=%0b",
                             bus_if.buf_commit, bus_if.rx_data_ready, o.commit, o.commit);
                end else if (o.commit && bus_if.rx_byte_count !== o.count) begin
                    n_err++;
                    $display("FAIL byte_count: got %0d, required %0d", bus_if.rx_byte_count, o.count);
                end
                if (o.hs != 2'd0) exp_hs_q.push_back(o.hs);
            end
        end
        if (bus_if.rx_data_ready && !bus_if.buf_commit) begin
            n_cmp++; n_err++;
            $display("FAIL ready_without_commit: got ready=1, required 0");
        end
        if (bus_if.tx_req && !prev_req) begin
            n_cmp++;
            if (exp_hs_q.size() == 0) begin
                n_err++;
                $display("FAIL tx_req_unexpected: got pid %0d, required no request", bus_if.tx_pid);
            end else begin
                h = exp_hs_q.pop_front();
                if (bus_if.tx_pid !== h) begin
                    n_err++;
                    $display("FAIL tx_pid: got %0d, required %0d", bus_if.tx_pid, h);
                end
            end
        end
        prev_req = bus_if.tx_req;
        bus_if.tx_ack = bus_if.tx_req && auto_ack;
    endtask

    task automatic send_pkt(input logic [2:0] p);
        bus_if.rx_packet = p;
        tick();
        bus_if.rx_packet = 3'd0;
    endtask

    task automatic send_out();
        send_pkt(3'd1);
        tick();
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic full);
        bus_if.store_rx_packet_data = 1'b1;
        bus_if.rx_packet_data       = b;
        bus_if.buf_full             = full;
        if (!full && m_count < 64) begin
            exp_wr_q.push_back(b);
            m_count++;
        end else begin
            m_ovf = 1'b1;
        end
        tick();
        bus_if.store_rx_packet_data = 1'b0;
        bus_if.buf_full             = 1'b0;
    endtask

    // DATA0 (tog=0) or DATA1 (tog=1) ending a transaction; model the outcome.
    task automatic send_data(input logic tog);
        out_t o;
        if (m_ovf) begin
            o = '{commit: 1'b0, count: 7'd0, hs: 2'd2};
        end else if (tog != m_toggle) begin
            o = '{commit: 1'b0, count: 7'd0, hs: 2'd1};
        end else begin
            o = '{commit: 1'b1, count: 7'(m_count), hs: 2'd1};
            m_toggle = ~m_toggle;
        end
        exp_out_q.push_back(o);
        send_pkt(tog ? 3'd4 : 3'd3);
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while ((bus_if.rx_busy || bus_if.tx_req) && i < 200) begin
            tick();
            i++;
        end
        n_cmp++;
        if (bus_if.rx_busy || bus_if.tx_req) begin
            n_err++;
            $display("FAIL %s_idle_timeout: got busy=%0b req=%0b, required 0", name,
                     bus_if.rx_busy, bus_if.tx_req);
        end
    endtask

    task automatic check_done(input string name);
        tick();
        n_cmp++;
        if (exp_wr_q.size() != 0 || exp_out_q.size() != 0 || exp_hs_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing: got pending wr=%0d out=%0d hs=%0d, required 0", name,
                     exp_wr_q.size(), exp_out_q.size(), exp_hs_q.size());
            exp_wr_q.delete(); exp_out_q.delete(); exp_hs_q.delete();
        end
        n_cmp++;
        if (bus_if.expected_toggle !== m_toggle) begin
            n_err++;
            $display("FAIL %s_toggle: got %0b, required %0b", name, bus_if.expected_toggle, m_toggle);
        end
        $display("done %s: compared=%0d mismatched=%0d", name, n_cmp, n_err);
    endtask

    task automatic test_reset();
        logic [22:0] outs;
        rst = 1'b1;
        repeat (3) tick();
        outs = {bus_if.buf_wr_en, bus_if.buf_wr_data, bus_if.buf_commit, bus_if.buf_rollback,
                bus_if.tx_req, bus_if.tx_pid, bus_if.rx_data_ready, bus_if.rx_byte_count,
                bus_if.rx_busy, bus_if.expected_toggle};
        n_cmp++;
        if (outs !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %06h, required 000000", outs);
        end
        rst = 1'b0;
        tick();
        $display("done reset: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_commit();
        logic [7:0] bytes_t1 [4];
        bytes_t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_out();
        foreach (bytes_t1[i]) send_byte(bytes_t1[i], 1'b0);
        send_data(1'b0);
        wait_idle("commit");
        n_cmp++;
        if (bus_if.rx_byte_count !== 7'd4) begin
            n_err++;
            $display("FAIL commit_count_hold: got %0d, required 4", bus_if.rx_byte_count);
        end
        check_done("commit");
    endtask

    task automatic test_retry();
        send_out();
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_data(1'b0);
        wait_idle("retry");
        check_done("retry");
    endtask

    task automatic test_overflow();
        send_out();
        for (int i = 0; i < 65; i++) send_byte(8'(i + 1), 1'b0);
        send_data(1'b1);
        wait_idle("overflow");
        check_done("overflow");
    endtask

    task automatic test_timeout();
        send_out();
        repeat (142) tick();
        n_cmp++;
        if (bus_if.rx_busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_early: got busy=%0b, required 1", bus_if.rx_busy);
        end
        tick();
        n_cmp++;
        if (bus_if.rx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_expire: got busy=%0b, required 0", bus_if.rx_busy);
        end
        check_done("timeout");
    endtask

    task automatic test_buf_full();
        send_out();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b0);
        send_data(m_toggle);
        wait_idle("buf_full");
        check_done("buf_full");
    endtask

    task automatic test_toggle_clear();
        bus_if.toggle_clear = 1'b1;
        tick();
        bus_if.toggle_clear = 1'b0;
        m_toggle = 1'b0;
        check_done("toggle_clear");
        // clear landing on the same cycle as a committing flip
        send_out();
        send_byte(8'h5A, 1'b0);
        send_data(1'b0);
        bus_if.toggle_clear = 1'b1;
        tick();
        bus_if.toggle_clear = 1'b0;
        m_toggle = 1'b0;
        wait_idle("clear_vs_flip");
        check_done("clear_vs_flip");
    endtask

    task automatic test_bad();
        send_out();
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hB3, 1'b0);
        exp_out_q.push_back('{commit: 1'b0, count: 7'd0, hs: 2'd0});
        send_pkt(3'd7);
        wait_idle("bad");
        check_done("bad");
    endtask

    task automatic test_rst_mid();
        logic [22:0] outs;
        send_out();
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        rst = 1'b1;
        tick();
        outs = {bus_if.buf_wr_en, bus_if.buf_wr_data, bus_if.buf_commit, bus_if.buf_rollback,
                bus_if.tx_req, bus_if.tx_pid, bus_if.rx_data_ready, bus_if.rx_byte_count,
                bus_if.rx_busy, bus_if.expected_toggle};
        n_cmp++;
        if (outs !== 23'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %06h, required 000000", outs);
        end
        rst = 1'b0;
        m_toggle = 1'b0;
        check_done("rst_mid");
    endtask

    task automatic test_zlp_hold();
        send_out();
        auto_ack = 1'b0;
        send_data(1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bus_if.rx_packet = 3'd1;
            if (i == 4) bus_if.rx_packet = 3'd0;
            tick();
            n_cmp++;
            if (bus_if.tx_req !== 1'b1) begin
                n_err++;
                $display("FAIL zlp_req_hold: got tx_req=%0b at cycle %0d, required 1", bus_if.tx_req, i);
            end
        end
        auto_ack = 1'b1;
        wait_idle("zlp");
        repeat (3) tick();
        n_cmp++;
        if (bus_if.rx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL zlp_out_dropped: got busy=%0b, required 0", bus_if.rx_busy);
        end
        n_cmp++;
        if (bus_if.rx_byte_count !== 7'd0) begin
            n_err++;
            $display("FAIL zlp_count: got %0d, required 0", bus_if.rx_byte_count);
        end
        check_done("zlp");
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 2; p++) begin
            send_out();
            send_byte(8'(8'hD0 + p), 1'b0);
            send_byte(8'(8'hE0 + p), 1'b0);
            send_data(m_toggle);
            wait_idle("back_to_back");
        end
        check_done("back_to_back");
    endtask

    initial begin
        bus_if.rx_packet            = 3'd0;
        bus_if.rx_packet_data       = 8'd0;
        bus_if.store_rx_packet_data = 1'b0;
        bus_if.buf_full             = 1'b0;
        bus_if.toggle_clear         = 1'b0;
        bus_if.tx_ack               = 1'b0;

        test_reset();
        test_commit();
        test_retry();
        test_overflow();
        test_timeout();
        test_buf_full();
        test_toggle_clear();
        test_bad();
        test_rst_mid();
        test_zlp_hold();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
